// File: rtl/legv8_pkg.sv
// Shared LEGv8 constants: instruction width, bubble encoding, opcodes and
// the default program image for the instruction ROM.
package legv8_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    localparam int IMEM_INIT_DEPTH = 64;

    // Default program; words beyond the listed ones are bubbles.
    localparam logic [INSTR_W-1:0] IMEM_INIT [IMEM_INIT_DEPTH] = '{
        0:  32'hF84AA022,
        1:  32'hF8554022,
        2:  32'hF80AA022,
        3:  32'hF8154022,
        4:  32'hB4000043,
        5:  32'hF8408064,
        6:  32'hF8010065,
        7:  32'hB4FFFF86,
        8:  32'h8B020021,
        9:  32'hCB030042,
        10: 32'h8A040063,
        11: 32'hAA050084,
        12: 32'hF84100A7,
        13: 32'hF80180E8,
        14: 32'hB4000109,
        15: 32'h17FFFFF1,
        default: BUBBLE_INSTR
    };

endpackage

// File: rtl/fetch_ifid_imem.sv
// Word-addressed combinational instruction ROM, contents taken from
// legv8_pkg::IMEM_INIT; entries past the image read as bubbles.
module imem
    import legv8_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]      addr,
    output logic [INSTR_W-1:0] rd
);

    logic [INSTR_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        if (i < IMEM_INIT_DEPTH) begin : g_init
            assign rom[i] = IMEM_INIT[i];
        end else begin : g_fill
            assign rom[i] = BUBBLE_INSTR;
        end
    end

    assign rd = rom[addr];

endmodule

// File: rtl/fetch_ifid.sv
// LEGv8 fetch stage: PC register, next-PC selection, ROM read and the IF/ID
// pipeline register with load-use stall and branch flush handling.
module fetch_ifid
    import legv8_pkg::*;
#(
    parameter int          N          = 64,
    parameter int          IMEM_DEPTH = 64,
    parameter logic [N-1:0] RESET_PC  = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_d,
    input  logic                pcsrc_e,
    input  logic [N-1:0]        pcbranch_e,
    output logic [N-1:0]        pc_f,
    output logic [INSTR_W-1:0]  instr_d,
    output logic [N-1:0]        pc_d,
    output logic                valid_d,
    output logic [31:0]         fetch_count
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [INSTR_W-1:0] instr_f;
    logic [N-1:0]       pc_plus4_f;

    // Byte address bits [1:0] and everything above the ROM span are dropped,
    // so fetch wraps modulo IMEM_DEPTH*4.
    imem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (AW)
    ) u_imem (
        .addr (pc_f[AW+1:2]),
        .rd   (instr_f)
    );

    assign pc_plus4_f = pc_f + N'(4);

    // ---- IF -> ID boundary ----
    // A taken branch outranks a stall: the stalled instruction is on the
    // wrong path anyway, so it is squashed rather than held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f        <= RESET_PC;
            instr_d     <= BUBBLE_INSTR;
            pc_d        <= '0;
            valid_d     <= 1'b0;
            fetch_count <= '0;
        end else if (pcsrc_e) begin
            pc_f        <= pcbranch_e;
            instr_d     <= BUBBLE_INSTR;
            pc_d        <= '0;
            valid_d     <= 1'b0;
        end else if (!stall_d) begin
            pc_f        <= pc_plus4_f;
            instr_d     <= instr_f;
            pc_d        <= pc_f;
            valid_d     <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_ifid.sv
// Directed plus randomized bench for fetch_ifid against a per-edge
// behavioural model of the fetch stage.
module tb_fetch_ifid;
    import legv8_pkg::*;

    localparam int N          = 64;
    localparam int IMEM_DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall_d;
    logic          pcsrc_e;
    logic [N-1:0]  pcbranch_e;
    logic [N-1:0]  pc_f;
    logic [31:0]   instr_d;
    logic [N-1:0]  pc_d;
    logic          valid_d;
    logic [31:0]   fetch_count;

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0] m_pc;
    logic [31:0]  m_instr;
    logic [N-1:0] m_pcd;
    logic         m_valid;
    logic [31:0]  m_cnt;

    fetch_ifid #(.N(N), .IMEM_DEPTH(IMEM_DEPTH), .RESET_PC('0)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_d     (stall_d),
        .pcsrc_e     (pcsrc_e),
        .pcbranch_e  (pcbranch_e),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .valid_d     (valid_d),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [N-1:0] addr);
        int idx;
        idx = int'((addr / 4) % IMEM_DEPTH);
        return IMEM_INIT[idx];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_instr = 32'h0; m_pcd = '0; m_valid = 1'b0; m_cnt = 32'd0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc_f"},        pc_f,        m_pc);
        chk({tag, ".instr_d"},     64'(instr_d), 64'(m_instr));
        chk({tag, ".pc_d"},        pc_d,        m_pcd);
        chk({tag, ".valid_d"},     64'(valid_d), 64'(m_valid));
        chk({tag, ".fetch_count"}, 64'(fetch_count), 64'(m_cnt));
    endtask

    // Called at a negedge: drive inputs, take one rising edge, advance the
    // model, then compare at the following negedge.
    task automatic step(input logic st, input logic br, input logic [N-1:0] tgt, input string tag);
        stall_d = st; pcsrc_e = br; pcbranch_e = tgt;
        @(posedge clk);
        if (br) begin
            m_pc = tgt; m_instr = 32'h0; m_pcd = '0; m_valid = 1'b0;
        end else if (!st) begin
            m_instr = rom_word(m_pc); m_pcd = m_pc; m_valid = 1'b1;
            m_cnt = m_cnt + 32'd1; m_pc = m_pc + 64'd4;
        end
        @(negedge clk);
        chk_all(tag);
    endtask

    initial begin
        reset = 1'b1; stall_d = 1'b0; pcsrc_e = 1'b0; pcbranch_e = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_all("reset");
        reset = 1'b0;

        step(0, 0, '0, "run1");
        step(0, 0, '0, "run2");
        chk("run2.instr_const", 64'(instr_d), 64'(32'hF8554022));
        chk("run2.pc_f_const", pc_f, 64'h8);
        step(0, 0, '0, "run3");
        chk("run3.instr_const", 64'(instr_d), 64'(32'hF80AA022));
        chk("run3.cnt_const", 64'(fetch_count), 64'd3);

        // Two stall edges then release
        step(1, 0, '0, "stall1");
        step(1, 0, '0, "stall2");
        chk("stall2.pc_f_const", pc_f, 64'hC);
        step(0, 0, '0, "unstall");
        chk("unstall.instr_const", 64'(instr_d), 64'(32'hF8154022));

        // Branch back to 0: one bubble, then target instruction
        step(0, 1, 64'h0, "br0");
        chk("br0.valid_const", 64'(valid_d), 64'd0);
        step(0, 0, '0, "br0.tgt");
        chk("br0.tgt_const", 64'(instr_d), 64'(32'hF84AA022));

        // Flush and stall together: flush wins
        step(1, 1, 64'h4, "brstall");
        chk("brstall.pc_f_const", pc_f, 64'h4);
        step(0, 0, '0, "brstall.tgt");
        chk("brstall.tgt_const", 64'(instr_d), 64'(32'hF8554022));

        // Address wrap within ROM span and across 2^N
        step(0, 1, 64'h100, "wrap100");
        step(0, 0, '0, "wrap100.tgt");
        chk("wrap100.const", 64'(instr_d), 64'(32'hF84AA022));
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, "wraptop");
        step(0, 0, '0, "wraptop.free");
        chk("wraptop.pc_f_const", pc_f, 64'h0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic st, br;
            logic [N-1:0] tgt;
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 4) == 0)
                tgt = {32'($urandom), 32'($urandom)};
            else
                tgt = 64'($urandom_range(0, 2 * IMEM_DEPTH - 1)) * 64'd4;
            step(st, br, tgt, "rand");
        end

        // Asynchronous reset between edges
        stall_d = 1'b0; pcsrc_e = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, '0, "post_rst");
        chk("post_rst.instr_const", 64'(instr_d), 64'(32'hF84AA022));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
